// File: rtl/cordic_atan2_mag.sv
// Iterative vectoring-mode CORDIC: signed Q1.14 (x,y) -> integer degrees and Q1.14 magnitude.
// Build option: define CORDIC_MAG_EN to include the magnitude gain-correction multiplier.
module cordic_atan2_mag #(
  parameter int ITERATIONS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  output logic signed [15:0] angle_out,
  output logic signed [15:0] magnitude_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_SCALE, S_OUT} state_t;

  localparam logic [4:0] LAST_STEP = 5'(ITERATIONS - 1);

  // atan(2^-i) in radians x 16384; entries past index 5 halve each step.
  function automatic logic signed [15:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_lut = 16'sh3244;
      5'd1:    atan_lut = 16'sh1DAC;
      5'd2:    atan_lut = 16'sh0FAE;
      5'd3:    atan_lut = 16'sh07F5;
      5'd4:    atan_lut = 16'sh03FF;
      5'd5:    atan_lut = 16'sh0200;
      5'd6:    atan_lut = 16'sh0100;
      5'd7:    atan_lut = 16'sh0080;
      5'd8:    atan_lut = 16'sh0040;
      5'd9:    atan_lut = 16'sh0020;
      5'd10:   atan_lut = 16'sh0010;
      5'd11:   atan_lut = 16'sh0008;
      5'd12:   atan_lut = 16'sh0004;
      5'd13:   atan_lut = 16'sh0002;
      5'd14:   atan_lut = 16'sh0001;
      default: atan_lut = 16'sh0000;
    endcase
  endfunction

  // Radians x 16384 to integer degrees: z * (180/pi * 64) / 2^20, rounded half-up.
  function automatic logic signed [15:0] round_deg(input logic signed [15:0] z);
    logic signed [31:0] prod;
    prod = $signed({{16{z[15]}}, z}) * 32'sd3667 + 32'sd524288;
    round_deg = 16'(prod >>> 20);
  endfunction

  // Undo the left-half-plane pre-rotation and keep the result in -180..179.
  function automatic logic signed [15:0] fold_deg(input logic signed [15:0] deg,
                                                  input logic flip,
                                                  input logic zero);
    logic signed [15:0] d;
    if (zero)
      d = 16'sd0;
    else if (flip)
      d = (deg <= 16'sd0) ? (deg + 16'sd180) : (deg - 16'sd180);
    else
      d = deg;
    if (d == 16'sd180)
      d = -16'sd180;
    fold_deg = d;
  endfunction

`ifdef CORDIC_MAG_EN
  // x * 1/K with 1/K = 0x26DD / 2^14 removes the accumulated CORDIC gain.
  function automatic logic signed [18:0] scale_mag(input logic signed [17:0] x);
    logic signed [33:0] prod;
    prod = $signed({{16{x[17]}}, x}) * 34'sd9949;
    scale_mag = prod[32:14];
  endfunction

  function automatic logic signed [15:0] sat_mag(input logic signed [18:0] m);
    if (m > 19'sd32767)
      sat_mag = 16'sh7FFF;
    else
      sat_mag = m[15:0];
  endfunction
`endif

  state_t             r_state;
  state_t             w_next;
  logic               w_load;
  logic               w_iter;
  logic               w_scale;
  logic               w_fin;

  logic [4:0]         r_count;
  logic               r_busy;
  logic               r_done;
  logic               r_flip;
  logic               r_zero;
  logic signed [15:0] r_angle;
  logic signed [15:0] r_mag;

  logic signed [17:0] r_x;
  logic signed [17:0] r_y;
  logic signed [15:0] r_z;
  logic signed [15:0] r_deg_raw;
`ifdef CORDIC_MAG_EN
  logic signed [18:0] r_mag_raw;
`endif

  logic signed [17:0] w_x_ext;
  logic signed [17:0] w_y_ext;
  logic signed [17:0] w_xs;
  logic signed [17:0] w_ys;
  logic signed [15:0] w_atan;

  assign w_x_ext = {{2{x_in[15]}}, x_in};
  assign w_y_ext = {{2{y_in[15]}}, y_in};
  assign w_xs    = r_x >>> r_count;
  assign w_ys    = r_y >>> r_count;
  assign w_atan  = atan_lut(r_count);

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ITER;
      S_ITER:  if (r_count == LAST_STEP) w_next = S_SCALE;
      S_SCALE: w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load  = 1'b0;
    w_iter  = 1'b0;
    w_scale = 1'b0;
    w_fin   = 1'b0;
    case (r_state)
      S_IDLE:  w_load  = start;
      S_ITER:  w_iter  = 1'b1;
      S_SCALE: w_scale = 1'b1;
      S_OUT:   w_fin   = 1'b1;
      default: ;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_flip  <= 1'b0;
      r_zero  <= 1'b0;
      r_angle <= 16'sd0;
      r_mag   <= 16'sd0;
    end else begin
      r_done <= w_fin;
      if (w_load) begin
        r_count <= 5'd0;
        r_busy  <= 1'b1;
        r_flip  <= x_in[15];
        r_zero  <= (x_in == 16'sd0) && (y_in == 16'sd0);
      end else if (r_done) begin
        r_busy <= 1'b0;
      end
      if (w_iter)
        r_count <= r_count + 5'd1;
      if (w_fin) begin
        r_angle <= fold_deg(r_deg_raw, r_flip, r_zero);
`ifdef CORDIC_MAG_EN
        r_mag   <= sat_mag(r_mag_raw);
`else
        r_mag   <= 16'sd0;
`endif
      end
    end
  end

  // Datapath: micro-rotations use the pre-update x, y, z
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_x <= x_in[15] ? -w_x_ext : w_x_ext;
      r_y <= x_in[15] ? -w_y_ext : w_y_ext;
      r_z <= 16'sd0;
    end else if (w_iter) begin
      if (!r_y[17]) begin
        r_x <= r_x + w_ys;
        r_y <= r_y - w_xs;
        r_z <= r_z + w_atan;
      end else begin
        r_x <= r_x - w_ys;
        r_y <= r_y + w_xs;
        r_z <= r_z - w_atan;
      end
    end else if (w_scale) begin
      r_deg_raw <= round_deg(r_z);
`ifdef CORDIC_MAG_EN
      r_mag_raw <= scale_mag(r_x);
`endif
    end
  end

  assign angle_out     = r_angle;
  assign magnitude_out = r_mag;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_cordic_atan2_mag.sv
// Directed bench for cordic_atan2_mag: latency, quadrants, saturation, start/reset abort, sin/cos round trip.
`timescale 1ns/1ps
module tb_cordic_atan2_mag;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic signed [15:0] angle_out;
  logic signed [15:0] magnitude_out;
  logic               busy;
  logic               done;

  int tests = 0;
  int fails = 0;

`ifdef CORDIC_MAG_EN
  localparam bit MAG_EN = 1'b1;
`else
  localparam bit MAG_EN = 1'b0;
`endif

  localparam int LAT = 18;

  always #5 clk = ~clk;

  cordic_atan2_mag #(.ITERATIONS(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .x_in          (x_in),
    .y_in          (y_in),
    .angle_out     (angle_out),
    .magnitude_out (magnitude_out),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp, input int tol);
    tests++;
    assert ((got >= exp - tol) && (got <= exp + tol)) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d +/- %0d", tag, got, exp, tol);
    end
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Launch one operation; return edges from the accepting edge to done and busy coverage.
  task automatic run_op(input logic signed [15:0] xv, input logic signed [15:0] yv,
                        output int lat, output logic bsy_ok);
    @(negedge clk);
    x_in  = xv;
    y_in  = yv;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    lat    = 0;
    bsy_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) bsy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b1) bsy_ok = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic signed [15:0] xv,
                          input logic signed [15:0] yv, input int exp_ang,
                          input int exp_mag, input int tol);
    int   lat;
    logic bo;
    run_op(xv, yv, lat, bo);
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_busy"}, bo, 1);
    chk({tag, "_angle"}, angle_out, exp_ang);
    chk_tol({tag, "_mag"}, magnitude_out, MAG_EN ? exp_mag : 0, MAG_EN ? tol : 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_clear"}, busy, 0);
  endtask

  int                 lat;
  logic               bo;
  int                 ndone;
  int                 seen_lat;
  logic signed [15:0] seen_ang;
  logic signed [15:0] seen_mag;
  logic signed [15:0] hold_ang;
  int                 diff;
  real                rad;
  logic signed [15:0] xv;
  logic signed [15:0] yv;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    x_in  = 16'sd0;
    y_in  = 16'sd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_angle", angle_out, 0);
    chk("reset_mag", magnitude_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    op_check("x_axis", 16'sh4000, 16'sh0000, 0, 16384, 4);
    op_check("diag45", 16'sh2D41, 16'sh2D41, 45, 16384, 4);
    op_check("neg_y", 16'sh0000, 16'shC000, -90, 16384, 4);
    op_check("pos_y", 16'sh0000, 16'sh4000, 90, 16384, 4);
    op_check("q2", 16'shD2BF, 16'sh2D41, 135, 16384, 4);
    op_check("q3", 16'shD2BF, 16'shD2BF, -135, 16384, 4);
    op_check("neg_x", 16'shC000, 16'sh0000, -180, 16384, 4);
    op_check("full_scale", 16'sh7FFF, 16'sh7FFF, 45, 32767, 0);
    op_check("origin", 16'sh0000, 16'sh0000, 0, 0, 0);

    // Results hold after the done pulse
    op_check("hold_src", 16'shD2BF, 16'sh2D41, 135, 16384, 4);
    hold_ang = angle_out;
    repeat (5) @(negedge clk);
    chk("hold_angle", angle_out, 135);
    chk("hold_stable", angle_out, hold_ang);

    // start pulses during an operation are ignored
    @(negedge clk);
    x_in  = 16'sh4000;
    y_in  = 16'sh0000;
    start = 1'b1;
    @(negedge clk);
    ndone    = 0;
    seen_lat = -1;
    seen_ang = 16'sh7FFF;
    seen_mag = 16'sh7FFF;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) begin
        ndone++;
        if (seen_lat < 0) begin
          seen_lat = k;
          seen_ang = angle_out;
          seen_mag = magnitude_out;
        end
      end
      start = (k == 3 || k == 10);
      if (start) begin
        x_in = 16'sh0000;
        y_in = 16'sh4000;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("restart_done_count", ndone, 1);
    chk("restart_latency", seen_lat, LAT);
    chk("restart_angle", seen_ang, 0);
    chk_tol("restart_mag", seen_mag, MAG_EN ? 16384 : 0, MAG_EN ? 4 : 0);

    // Reset mid-operation aborts without a done pulse
    op_check("pre_abort", 16'shD2BF, 16'sh2D41, 135, 16384, 4);
    @(negedge clk);
    x_in  = 16'sh2D41;
    y_in  = 16'sh2D41;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_angle", angle_out, 0);
    chk("abort_mag", magnitude_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    op_check("post_abort", 16'shD2BF, 16'shD2BF, -135, 16384, 4);

    // Round trip from sin/cos vectors at every integer degree
    for (int d = -180; d < 180; d++) begin
      rad = d * 3.14159265358979 / 180.0;
      xv  = 16'(rnd(16384.0 * $cos(rad)));
      yv  = 16'(rnd(16384.0 * $sin(rad)));
      run_op(xv, yv, lat, bo);
      chk($sformatf("rt_latency_%0d", d), lat, LAT);
      diff = int'(angle_out) - d;
      if (diff > 180) diff -= 360;
      if (diff < -180) diff += 360;
      chk_tol($sformatf("rt_angle_%0d", d), diff, 0, 1);
      chk_tol($sformatf("rt_mag_%0d", d), magnitude_out, MAG_EN ? 16384 : 0, MAG_EN ? 8 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no completion within 2 ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
